btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 192 +++++++++++++++++++
 tb/tb_btn_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer: clean level, press/release strobes, press count.
// Optional long-press strobe is compiled in with `define BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned LONG_W          = 26
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn1,
  output logic       o_btn,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [7:0] o_press_cnt
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  if (DEBOUNCE_CYCLES < 32'd2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 32'd1 || LONG_W < 32'd1) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES and LONG_W must be at least 1");
  end

  logic       s1_r, s2_r;
  state_t     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic       btn_r, btn_s;
  logic       press_r, press_s;
  logic       release_r, release_s;
  logic [7:0] press_cnt_r, press_cnt_s;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= i_btn1;
      s2_r <= s1_r;
    end
  end

  // State, qualification counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE_LOW;
      cnt_r       <= '0;
      btn_r       <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      press_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      btn_r       <= btn_s;
      press_r     <= press_s;
      release_r   <= release_s;
      press_cnt_r <= press_cnt_s;
    end
  end

  // Next-state logic; a change is accepted once the opposite level has held for DEBOUNCE_CYCLES samples
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    btn_s       = btn_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    press_cnt_s = press_cnt_r;
    case (state_r)
      IDLE_LOW: begin
        if (s2_r) begin
          state_s = WAIT_HIGH;
          cnt_s   = CNT_W'(1'b1);
        end else begin
          cnt_s   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_r) begin
          state_s = IDLE_LOW;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s     = IDLE_HIGH;
          btn_s       = 1'b1;
          press_s     = 1'b1;
          press_cnt_s = press_cnt_r + 8'd1;
          cnt_s       = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_r) begin
          state_s = WAIT_LOW;
          cnt_s   = CNT_W'(1'b1);
        end else begin
          cnt_s   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_r) begin
          state_s = IDLE_HIGH;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE_LOW;
          btn_s     = 1'b0;
          release_s = 1'b1;
          cnt_s     = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE_LOW;
        cnt_s   = '0;
        btn_s   = 1'b0;
      end
    endcase
  end

  assign o_btn       = btn_r;
  assign o_press     = press_r;
  assign o_release   = release_r;
  assign o_press_cnt = press_cnt_r;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 32'd1);

  logic [LONG_W-1:0] long_cnt_r, long_cnt_s;
  logic              long_fired_r, long_fired_s;
  logic              long_r, long_s;

  // Long-press counter, one-strobe-per-press flag and strobe register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      long_cnt_r   <= '0;
      long_fired_r <= 1'b0;
      long_r       <= 1'b0;
    end else begin
      long_cnt_r   <= long_cnt_s;
      long_fired_r <= long_fired_s;
      long_r       <= long_s;
    end
  end

  // The fired flag survives a bounce back into IDLE_HIGH so a press strobes at most once
  always_comb begin
    long_cnt_s   = long_cnt_r;
    long_fired_s = long_fired_r;
    long_s       = 1'b0;
    if (release_s) begin
      long_cnt_s   = '0;
      long_fired_s = 1'b0;
    end else if (state_s == IDLE_HIGH && state_r != IDLE_HIGH) begin
      long_cnt_s = '0;
      if (press_s) begin
        long_fired_s = 1'b0;
      end else begin
        long_fired_s = long_fired_r;
      end
    end else if (state_r == IDLE_HIGH || state_r == WAIT_LOW) begin
      if (long_cnt_r != LONG_LAST) begin
        long_cnt_s = long_cnt_r + LONG_W'(1'b1);
      end else if (!long_fired_r) begin
        long_s       = 1'b1;
        long_fired_s = 1'b1;
      end else begin
        long_cnt_s = long_cnt_r;
      end
    end else begin
      long_cnt_s = long_cnt_r;
    end
  end

  assign o_long = long_r;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       o_btn, o_press, o_release, o_long;
  logic [7:0] o_press_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       e_btn;
    logic       e_press;
    logic       e_rel;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .LONG_CYCLES(10),
    .LONG_W(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn1(btn),
    .o_btn(o_btn),
    .o_press(o_press),
    .o_release(o_release),
    .o_long(o_long),
    .o_press_cnt(o_press_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic eb, input logic ep,
                     input logic er, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.btn = b; v.e_btn = eb; v.e_press = ep; v.e_rel = er; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [11:0] pat;
    int presses, both, early, long_seen, long_at;

    rst = 1'b1;
    btn = 1'b0;

    // clean press, release, then reset and bounce pattern
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    pat = 12'b1111_1011_1011;
    for (int k = 0; k < 12; k++) add(1'b0, pat[k], 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      btn = vecs[i].btn;
      step();
      chk($sformatf("v%0d o_btn", i), 32'(o_btn), 32'(vecs[i].e_btn));
      chk($sformatf("v%0d o_press", i), 32'(o_press), 32'(vecs[i].e_press));
      chk($sformatf("v%0d o_release", i), 32'(o_release), 32'(vecs[i].e_rel));
      chk($sformatf("v%0d o_press_cnt", i), 32'(o_press_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d o_long", i), 32'(o_long), 32'd0);
    end

    // 256 press/release cycles: count wraps 255 -> 0
    rst = 1'b1; btn = 1'b0;
    step();
    rst = 1'b0;
    presses = 0;
    both = 0;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1;
      for (int j = 0; j < 6; j++) begin
        step();
        if (o_press) presses++;
        if (o_press && o_release) both++;
      end
      if (i == 254) chk("wrap cnt 255", 32'(o_press_cnt), 32'd255);
      if (i == 255) chk("wrap cnt 0", 32'(o_press_cnt), 32'd0);
      btn = 1'b0;
      for (int j = 0; j < 6; j++) begin
        step();
        if (o_press) presses++;
        if (o_press && o_release) both++;
      end
      if (i == 0) begin
        chk("release keeps cnt", 32'(o_press_cnt), 32'd1);
        chk("release level", 32'(o_btn), 32'd0);
      end
    end
    chk("wrap press strobes", 32'(presses), 32'd256);
    chk("press and release together", 32'(both), 32'd0);

    // reset while qualifying with cnt=2, button kept held
    rst = 1'b1; btn = 1'b0;
    step();
    rst = 1'b0; btn = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst o_btn", 32'(o_btn), 32'd0);
    chk("midrst o_press", 32'(o_press), 32'd0);
    chk("midrst o_release", 32'(o_release), 32'd0);
    chk("midrst o_press_cnt", 32'(o_press_cnt), 32'd0);
    chk("midrst o_long", 32'(o_long), 32'd0);
    rst = 1'b0;
    early = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (o_press || o_btn) early++;
    end
    chk("requal early activity", 32'(early), 32'd0);
    step();
    chk("requal o_press", 32'(o_press), 32'd1);
    chk("requal o_btn", 32'(o_btn), 32'd1);
    chk("requal o_press_cnt", 32'(o_press_cnt), 32'd1);

    // keep holding: long-press strobe
    long_seen = 0;
    long_at = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (o_long) begin
        long_seen++;
        if (long_at < 0) long_at = j;
      end
    end
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    chk("long strobe count", 32'(long_seen), 32'd1);
    chk("long strobe cycle", 32'(long_at), 32'd10);
`else
    chk("long strobe count", 32'(long_seen), 32'd0);
`endif
    chk("held o_btn", 32'(o_btn), 32'd1);
    chk("held o_press_cnt", 32'(o_press_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
